ram_tdp_sc: RTL and testbench
=============================

RAM_TDP_SC -- requirements
Module: ram_tdp_sc

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, word width in bits (multiple of 8).
REQ-002 SHALL have parameter DATA_DEPTH, default 1024, number of words.
REQ-003 SHALL have parameter ADDR_WIDTH, default 10, address width; clog2(DATA_DEPTH) <= ADDR_WIDTH.
REQ-004 SHALL have parameter RAM_STYLE_VAL, default "block", synthesis ram_style attribute on the array.
REQ-005 SHALL have parameters MODEA/MODEB, default "NO CHANGE", per-port write mode: "READ FIRST" | "WRITE FIRST" | "NO CHANGE".
REQ-006 SHALL have parameter OUT_REG, default 0, 1 adds output pipeline register per port.
REQ-007 SHALL use one clock; reset is synchronous and active-low (clk, rst_n).
REQ-008 clk  input  1  rising-edge clock for both ports.
REQ-009 rst_n  input  1  synchronous active-low reset.
REQ-010 ena / enb  input  1  port enable; no read or write when 0.
REQ-011 wea / web  input  DATA_WIDTH/8  byte write enables; any bit set = write cycle.
REQ-012 addra / addrb  input  ADDR_WIDTH  word address.
REQ-013 dina / dinb  input  DATA_WIDTH  write data.
REQ-014 douta / doutb  output  DATA_WIDTH  read data.
REQ-015 coll  output  1  one-cycle pulse on same-address collision.
REQ-016 coll_cnt  output  16  saturating collision count.

Function
REQ-017 Write: on clk with en=1, bytes with we[i]=1 at addr SHALL update; others unchanged.
REQ-018 Read latency SHALL be 1 cycle (OUT_REG=0) or 2 cycles (OUT_REG=1) from en=1 to dout.
REQ-019 en=0: dout SHALL hold its previous value (both pipeline stages hold).
REQ-020 READ FIRST write cycle: dout SHALL show pre-write word.
REQ-021 WRITE FIRST write cycle: dout SHALL show post-write word (new bytes merged with old unwritten bytes).
REQ-022 NO CHANGE write cycle: dout SHALL hold previous value.
REQ-023 Addresses >= DATA_DEPTH: writes SHALL be ignored; reads SHALL return 0.
REQ-024 Cross-port read/write same address same cycle: reading port SHALL return pre-write word.
REQ-025 Both ports write same address same cycle: port A bytes SHALL win on overlapping byte lanes; non-overlapping lanes SHALL take each port's data.
REQ-026 Collision = ena & enb & addra==addrb & (|wea | |web), address in range.
REQ-027 Collision SHALL not alter REQ-024/025 resolution.

Reset
REQ-028 rst_n=0 at clk edge SHALL clear douta, doutb, both pipeline stages, coll, coll_cnt to 0.
REQ-029 Memory array SHALL NOT be reset; contents persist through reset.
REQ-030 Writes presented during rst_n=0 SHALL be ignored; reads restart after release with full latency.

Configuration
REQ-031 Macro RAM_TDP_COLL_DET_EN defined: coll SHALL pulse 1 cycle after each collision cycle; coll_cnt SHALL increment per collision, saturating at 16'hFFFF.
REQ-032 Macro undefined: coll and coll_cnt SHALL be tied 0, no detection logic; REQ-025 resolution unchanged.

Verification
REQ-033 Write A addr 0..9 data i*5, read 0..9 on A (OUT_REG=0) -> douta = 0,5,...,45 one cycle after each address.
REQ-034 Write B addr 11..19 data i*i, OUT_REG=1 -> doutb = 121..361 two cycles after each read address.
REQ-035 Preload addr 3 = 32'h11111111; same cycle A writes 32'hAAAAAAAA wea=4'b0011, B writes 32'hBBBBBBBB web=4'b1110 to addr 3 -> readback 32'hBBBBAAAA, coll=1 once, coll_cnt=1 (macro defined), 0/0 undefined.
REQ-036 Addr 5 = 25; A writes 99 to addr 5 with MODEA = READ FIRST / WRITE FIRST / NO CHANGE -> douta = 25 / 99 / prior value.
REQ-037 A writes addr 7 = 77 while B reads addr 7 same cycle -> doutb old value; next B read -> 77.
REQ-038 Write addr 2 = 50, assert rst_n=0 mid-read-stream for 2 cycles -> douta/doutb/coll_cnt = 0 during reset; after release read addr 2 -> 50.

Source files
------------

// File: rtl/ram_tdp_sc.sv
// ---------------------------------------------------------------------------
// ram_tdp_sc -- true dual-port, single-clock RAM with byte write enables.
//
// Two independent read/write ports (A and B) share one rising-edge clock.
// Each port has its own write mode ("READ FIRST", "WRITE FIRST", "NO CHANGE")
// and an optional second output register stage (OUT_REG=1).
//
// Optional feature (compile-time macro):
//   RAM_TDP_COLL_DET_EN  -- when defined, same-address collisions are
//                           detected: coll pulses one cycle after each
//                           collision and coll_cnt counts them (saturating).
//                           When undefined, coll/coll_cnt are tied to 0.
//
// Ports:
//   clk       in   1           rising-edge clock for both ports
//   rst_n     in   1           synchronous active-low reset (output path only)
//   ena/enb   in   1           port enable; no read or write when 0
//   wea/web   in   DW/8        byte write enables; any bit set = write cycle
//   addra/b   in   ADDR_WIDTH  word address
//   dina/b    in   DW          write data
//   douta/b   out  DW          read data
//   coll      out  1           one-cycle collision pulse
//   coll_cnt  out  16          saturating collision count
//
// Behaviour notes:
//   - The memory array is never reset; only the output path and collision
//     logic are cleared. Writes are suppressed while rst_n is low.
//   - Addresses >= DATA_DEPTH: writes are dropped and reads return 0.
//   - Cross-port read of an address written in the same cycle returns the
//     pre-write word. On a dual write to the same word, port A owns every
//     byte lane it enables; port B fills the remaining enabled lanes.
// ---------------------------------------------------------------------------
module ram_tdp_sc #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned DATA_DEPTH    = 1024,
    parameter int unsigned ADDR_WIDTH    = 10,
    parameter string       RAM_STYLE_VAL = "block",
    parameter string       MODEA         = "NO CHANGE",
    parameter string       MODEB         = "NO CHANGE",
    parameter int unsigned OUT_REG       = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    // port A
    input  logic                      ena,
    input  logic [DATA_WIDTH/8-1:0]   wea,
    input  logic [ADDR_WIDTH-1:0]     addra,
    input  logic [DATA_WIDTH-1:0]     dina,
    output logic [DATA_WIDTH-1:0]     douta,
    // port B
    input  logic                      enb,
    input  logic [DATA_WIDTH/8-1:0]   web,
    input  logic [ADDR_WIDTH-1:0]     addrb,
    input  logic [DATA_WIDTH-1:0]     dinb,
    output logic [DATA_WIDTH-1:0]     doutb,
    // collision reporting
    output logic                      coll,
    output logic [15:0]               coll_cnt
);

    localparam int unsigned NB    = DATA_WIDTH / 8;
    localparam int unsigned IDX_W = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1;

    localparam bit A_RF = (MODEA == "READ FIRST");
    localparam bit A_WF = (MODEA == "WRITE FIRST");
    localparam bit B_RF = (MODEB == "READ FIRST");
    localparam bit B_WF = (MODEB == "WRITE FIRST");

    // Elaboration-time parameter sanity check.
    if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH == 0 || IDX_W > ADDR_WIDTH ||
        RAM_STYLE_VAL == "" ||
        !(A_RF || A_WF || MODEA == "NO CHANGE") ||
        !(B_RF || B_WF || MODEB == "NO CHANGE")) begin : g_bad_cfg
        $error("ram_tdp_sc: invalid parameter configuration");
    end

    // -----------------------------------------------------------------------
    // Storage
    // -----------------------------------------------------------------------
    (* ram_style = RAM_STYLE_VAL *)
    logic [DATA_WIDTH-1:0] mem_q [DATA_DEPTH];

    // -----------------------------------------------------------------------
    // Address decode
    // -----------------------------------------------------------------------
    logic                  inr_a;
    logic                  inr_b;
    logic                  wr_a;
    logic                  wr_b;
    logic [IDX_W-1:0]      idx_a;
    logic [IDX_W-1:0]      idx_b;
    logic [DATA_WIDTH-1:0] old_a;
    logic [DATA_WIDTH-1:0] old_b;

    assign idx_a = addra[IDX_W-1:0];
    assign idx_b = addrb[IDX_W-1:0];
    assign inr_a = (32'(addra) < DATA_DEPTH);
    assign inr_b = (32'(addrb) < DATA_DEPTH);
    assign wr_a  = ena & (|wea);
    assign wr_b  = enb & (|web);

    // Pre-write contents as seen this cycle; out-of-range reads return 0.
    assign old_a = inr_a ? mem_q[idx_a] : '0;
    assign old_b = inr_b ? mem_q[idx_b] : '0;

    // Merge enabled bytes of new_w over old_w.
    function automatic logic [DATA_WIDTH-1:0] merge_bytes(
        input logic [DATA_WIDTH-1:0] old_w,
        input logic [DATA_WIDTH-1:0] new_w,
        input logic [NB-1:0]         be
    );
        logic [DATA_WIDTH-1:0] res;
        res = old_w;
        for (int unsigned i = 0; i < NB; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_w[8*i +: 8];
            end
        end
        return res;
    endfunction

    // -----------------------------------------------------------------------
    // Write path. Port B is assigned first so port A's later non-blocking
    // assignment wins on any byte lane both ports write to the same word.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst_n) begin
            for (int unsigned i = 0; i < NB; i++) begin
                if (enb && inr_b && web[i]) begin
                    mem_q[idx_b][8*i +: 8] <= dinb[8*i +: 8];
                end
                if (ena && inr_a && wea[i]) begin
                    mem_q[idx_a][8*i +: 8] <= dina[8*i +: 8];
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Read stage 1 (per-port write-mode handling)
    // -----------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] rd1a_d;
    logic [DATA_WIDTH-1:0] rd1a_q;
    logic [DATA_WIDTH-1:0] rd1b_d;
    logic [DATA_WIDTH-1:0] rd1b_q;

    always_comb begin
        rd1a_d = rd1a_q;
        if (ena) begin
            if (!wr_a || A_RF) begin
                rd1a_d = old_a;
            end else if (A_WF) begin
                rd1a_d = inr_a ? merge_bytes(old_a, dina, wea) : '0;
            end
        end
    end

    always_comb begin
        rd1b_d = rd1b_q;
        if (enb) begin
            if (!wr_b || B_RF) begin
                rd1b_d = old_b;
            end else if (B_WF) begin
                rd1b_d = inr_b ? merge_bytes(old_b, dinb, web) : '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd1a_q <= '0;
            rd1b_q <= '0;
        end else begin
            rd1a_q <= rd1a_d;
            rd1b_q <= rd1b_d;
        end
    end

    // -----------------------------------------------------------------------
    // Optional read stage 2. It advances only in the cycle after stage 1 was
    // loaded, so an idle port holds both stages while a lone read still
    // reaches the output two cycles after it was issued.
    // -----------------------------------------------------------------------
    if (OUT_REG != 0) begin : g_out_reg
        logic                  ld_a;
        logic                  ld_b;
        logic                  lda_q;
        logic                  ldb_q;
        logic [DATA_WIDTH-1:0] rd2a_q;
        logic [DATA_WIDTH-1:0] rd2b_q;

        assign ld_a = ena & (!wr_a | A_RF | A_WF);
        assign ld_b = enb & (!wr_b | B_RF | B_WF);

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                lda_q  <= 1'b0;
                ldb_q  <= 1'b0;
                rd2a_q <= '0;
                rd2b_q <= '0;
            end else begin
                lda_q <= ld_a;
                ldb_q <= ld_b;
                if (lda_q) begin
                    rd2a_q <= rd1a_q;
                end
                if (ldb_q) begin
                    rd2b_q <= rd1b_q;
                end
            end
        end

        assign douta = rd2a_q;
        assign doutb = rd2b_q;
    end else begin : g_no_out_reg
        assign douta = rd1a_q;
        assign doutb = rd1b_q;
    end

    // -----------------------------------------------------------------------
    // Collision detection
    // -----------------------------------------------------------------------
`ifdef RAM_TDP_COLL_DET_EN
    logic        coll_d;
    logic        coll_q;
    logic [15:0] cnt_d;
    logic [15:0] cnt_q;

    always_comb begin
        coll_d = ena & enb & (addra == addrb) & (wr_a | wr_b) & inr_a;
        cnt_d  = cnt_q;
        if (coll_d && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            coll_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            coll_q <= coll_d;
            cnt_q  <= cnt_d;
        end
    end

    assign coll     = coll_q;
    assign coll_cnt = cnt_q;
`else
    assign coll     = 1'b0;
    assign coll_cnt = '0;
`endif

endmodule

// File: tb/tb_ram_tdp_sc.sv
// ---------------------------------------------------------------------------
// tb_ram_tdp_sc -- directed self-checking bench for ram_tdp_sc.
//
// Three instances share all inputs and differ only in write mode / output
// register configuration:
//   u0: A=NO CHANGE   B=NO CHANGE   OUT_REG=0
//   u1: A=READ FIRST  B=READ FIRST  OUT_REG=1
//   u2: A=WRITE FIRST B=WRITE FIRST OUT_REG=0
// Depth is 24 words with a 5-bit address so addresses 24..31 are out of range.
// ---------------------------------------------------------------------------
module tb_ram_tdp_sc;

    localparam int unsigned DW = 32;
    localparam int unsigned DD = 24;
    localparam int unsigned AW = 5;
    localparam int unsigned NB = DW / 8;

`ifdef RAM_TDP_COLL_DET_EN
    localparam logic [31:0] CE = 32'd1;
`else
    localparam logic [31:0] CE = 32'd0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ena;
    logic          enb;
    logic [NB-1:0] wea;
    logic [NB-1:0] web;
    logic [AW-1:0] addra;
    logic [AW-1:0] addrb;
    logic [DW-1:0] dina;
    logic [DW-1:0] dinb;

    logic [DW-1:0] douta0, doutb0, douta1, doutb1, douta2, doutb2;
    logic          coll0, coll1, coll2;
    logic [15:0]   cnt0, cnt1, cnt2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ram_tdp_sc #(.DATA_WIDTH(DW), .DATA_DEPTH(DD), .ADDR_WIDTH(AW),
                 .MODEA("NO CHANGE"), .MODEB("NO CHANGE"), .OUT_REG(0)) u0 (
        .clk(clk), .rst_n(rst_n),
        .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(douta0),
        .enb(enb), .web(web), .addrb(addrb), .dinb(dinb), .doutb(doutb0),
        .coll(coll0), .coll_cnt(cnt0));

    ram_tdp_sc #(.DATA_WIDTH(DW), .DATA_DEPTH(DD), .ADDR_WIDTH(AW),
                 .MODEA("READ FIRST"), .MODEB("READ FIRST"), .OUT_REG(1)) u1 (
        .clk(clk), .rst_n(rst_n),
        .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(douta1),
        .enb(enb), .web(web), .addrb(addrb), .dinb(dinb), .doutb(doutb1),
        .coll(coll1), .coll_cnt(cnt1));

    ram_tdp_sc #(.DATA_WIDTH(DW), .DATA_DEPTH(DD), .ADDR_WIDTH(AW),
                 .MODEA("WRITE FIRST"), .MODEB("WRITE FIRST"), .OUT_REG(0)) u2 (
        .clk(clk), .rst_n(rst_n),
        .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(douta2),
        .enb(enb), .web(web), .addrb(addrb), .dinb(dinb), .doutb(doutb2),
        .coll(coll2), .coll_cnt(cnt2));

    // Drive one cycle of stimulus at the falling edge; return 1 time unit
    // after the following rising edge so outputs can be sampled.
    task automatic step(input logic ea, input logic [NB-1:0] wa, input int aa,
                        input logic [DW-1:0] da,
                        input logic eb, input logic [NB-1:0] wb, input int ab,
                        input logic [DW-1:0] db);
        @(negedge clk);
        ena   = ea;
        wea   = wa;
        addra = AW'(aa);
        dina  = da;
        enb   = eb;
        web   = wb;
        addrb = AW'(ab);
        dinb  = db;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, '0, 0, '0, 1'b0, '0, 0, '0);
    endtask

    task automatic chk(input string tag, input logic [DW-1:0] obs,
                       input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        ena = 1'b0; enb = 1'b0; wea = '0; web = '0;
        addra = '0; addrb = '0; dina = '0; dinb = '0;

        // ---- reset state ----
        idle();
        idle();
        chk("rst_douta0", douta0, 32'd0);
        chk("rst_doutb0", doutb0, 32'd0);
        chk("rst_douta1", douta1, 32'd0);
        chk("rst_doutb1", doutb1, 32'd0);
        chk("rst_douta2", douta2, 32'd0);
        chk("rst_coll",   32'(coll0), 32'd0);
        chk("rst_cnt",    32'(cnt0),  32'd0);
        rst_n = 1'b1;

        // ---- port A writes 0..9 = i*5 (write-first shows new word) ----
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 4'hF, i, DW'(i * 5), 1'b0, '0, 0, '0);
            chk($sformatf("wf_wr_a[%0d]", i), douta2, DW'(i * 5));
        end
        // ---- port A reads 0..9: 1-cycle (u0,u2) and 2-cycle (u1) latency ----
        for (int i = 0; i < 10; i++) begin
            step(1'b1, '0, i, '0, 1'b0, '0, 0, '0);
            chk($sformatf("rd_a0[%0d]", i), douta0, DW'(i * 5));
            chk($sformatf("rd_a2[%0d]", i), douta2, DW'(i * 5));
            if (i > 0) chk($sformatf("rd_a1[%0d]", i), douta1, DW'((i - 1) * 5));
        end
        idle();
        chk("rd_a1_tail", douta1, 32'd45);
        chk("hold_a0",    douta0, 32'd45);

        // ---- port B writes 11..19 = i*i, reads back ----
        for (int i = 11; i < 20; i++) begin
            step(1'b0, '0, 0, '0, 1'b1, 4'hF, i, DW'(i * i));
            chk($sformatf("wf_wr_b[%0d]", i), doutb2, DW'(i * i));
        end
        for (int i = 11; i < 20; i++) begin
            step(1'b0, '0, 0, '0, 1'b1, '0, i, '0);
            chk($sformatf("rd_b0[%0d]", i), doutb0, DW'(i * i));
            if (i > 11) chk($sformatf("rd_b1[%0d]", i), doutb1, DW'((i - 1) * (i - 1)));
        end
        idle();
        chk("rd_b1_tail", doutb1, 32'd361);
        chk("hold_b0",    doutb0, 32'd361);

        // ---- dual write to addr 3 with overlapping byte lanes ----
        step(1'b1, 4'hF, 3, 32'h1111_1111, 1'b0, '0, 0, '0);
        step(1'b1, 4'b0011, 3, 32'hAAAA_AAAA, 1'b1, 4'b1110, 3, 32'hBBBB_BBBB);
        chk("coll_pulse", 32'(coll0), CE);
        chk("coll_cnt1",  32'(cnt0),  CE);
        chk("nc_hold_a",  douta0, 32'd45);
        chk("nc_hold_b",  doutb0, 32'd361);
        chk("wf_coll_a",  douta2, 32'h1111_AAAA);
        chk("wf_coll_b",  doutb2, 32'hBBBB_BB11);
        step(1'b1, '0, 3, '0, 1'b0, '0, 0, '0);
        chk("coll_drop",  32'(coll0), 32'd0);
        chk("coll_cnt1b", 32'(cnt0),  CE);
        chk("dual_wr_rd", douta0, 32'hBBBB_AAAA);
        chk("rf_coll_a",  douta1, 32'h1111_1111);

        // ---- write modes on port A: addr 5 holds 25, write 99 ----
        step(1'b1, '0, 4, '0, 1'b0, '0, 0, '0);
        chk("pre_a0",     douta0, 32'd20);
        chk("rf_pipe",    douta1, 32'hBBBB_AAAA);
        step(1'b1, 4'hF, 5, 32'd99, 1'b0, '0, 0, '0);
        chk("nc_mode",    douta0, 32'd20);
        chk("wf_mode",    douta2, 32'd99);
        chk("rf_pipe2",   douta1, 32'd20);
        idle();
        chk("rf_mode",    douta1, 32'd25);

        // ---- cross-port: A writes 7=77 while B reads 7 ----
        step(1'b1, 4'hF, 7, 32'd77, 1'b1, '0, 7, '0);
        chk("xport_old",  doutb0, 32'd35);
        chk("xport_coll", 32'(coll0), CE);
        chk("coll_cnt2",  32'(cnt0),  2 * CE);
        step(1'b0, '0, 0, '0, 1'b1, '0, 7, '0);
        chk("xport_new",  doutb0, 32'd77);

        // ---- out-of-range and top-of-range addresses ----
        step(1'b1, 4'hF, 30, 32'hDEAD_BEEF, 1'b1, '0, 30, '0);
        chk("oor_rd_b",   doutb0, 32'd0);
        chk("oor_wf_a",   douta2, 32'd0);
        chk("oor_nocoll", 32'(coll0), 32'd0);
        step(1'b1, '0, 30, '0, 1'b1, '0, 6, '0);
        chk("oor_rd_a",   douta0, 32'd0);
        chk("no_alias",   doutb0, 32'd30);
        step(1'b1, 4'hF, 23, 32'hCAFE_F00D, 1'b0, '0, 0, '0);
        step(1'b0, '0, 0, '0, 1'b1, '0, 23, '0);
        chk("top_addr",   doutb0, 32'hCAFE_F00D);

        // ---- reset in the middle of a read stream ----
        step(1'b1, 4'hF, 2, 32'd50, 1'b0, '0, 0, '0);
        step(1'b1, '0, 2, '0, 1'b1, '0, 2, '0);
        chk("pre_rst_a",  douta0, 32'd50);
        chk("pre_rst_b",  doutb0, 32'd50);
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 4'hF, 2, 32'h0000_1234, 1'b1, '0, 2, '0);
            chk($sformatf("in_rst_a0[%0d]", i), douta0, 32'd0);
            chk($sformatf("in_rst_b0[%0d]", i), doutb0, 32'd0);
            chk($sformatf("in_rst_a1[%0d]", i), douta1, 32'd0);
            chk($sformatf("in_rst_cnt[%0d]", i), 32'(cnt0), 32'd0);
        end
        rst_n = 1'b1;
        step(1'b1, '0, 2, '0, 1'b1, '0, 2, '0);
        chk("post_rst_a0", douta0, 32'd50);
        chk("post_rst_b0", doutb0, 32'd50);
        chk("post_rst_a1", douta1, 32'd0);
        step(1'b1, '0, 2, '0, 1'b1, '0, 2, '0);
        chk("post_rst_a1b", douta1, 32'd50);
        chk("post_rst_b1b", doutb1, 32'd50);
        chk("post_rst_cnt", 32'(cnt0), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
